// File: rtl/mem_lsu_if.sv
// Data-bus bundle between the memory-access stage and the data memory.
// master: stage side (drives request/address/enables/write data), slave: memory side.
// Ports: dbus_req/we/addr/sel/wdata toward memory; dbus_rdata/ack back from memory.
interface mem_lsu_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_wdata;
  logic [31:0] dbus_rdata;
  logic        dbus_ack;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
    input  dbus_rdata, dbus_ack
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
    output dbus_rdata, dbus_ack
  );
endinterface

// File: rtl/mem_lsu.sv
// Purpose: pipeline memory-access stage; passes ALU/HI-LO results through, runs load/store bus cycles.
// Latency: 0 cycles for non-memory ops; memory ops take request cycle(s) until ack, then one DONE cycle.
// Backpressure: stallreq holds PC..EX/MEM while a bus request is outstanding; a bubble enters MEM/WB.
// Ports: clk/rst (async active-low); mem_* from EX/MEM; bus = data-bus master; wb_* to MEM/WB;
//        stallreq to hazard unit; exc_adel/exc_ades flag misaligned loads/stores.
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_waddr,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_hi,
  input  logic [31:0] mem_lo,
  input  logic        mem_whilo,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  mem_lsu_if.master   bus,
  output logic [4:0]  wb_waddr,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic [31:0] wb_hi,
  output logic [31:0] wb_lo,
  output logic        wb_whilo,
  output logic        stallreq,
  output logic        exc_adel,
  output logic        exc_ades
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] rdata_q;
  logic        req;
  logic        capture;
  logic        is_load, is_store, misaligned;
  logic [1:0]  off;
  logic [3:0]  lane_sel;
  logic [31:0] store_dat;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;

  assign off = mem_addr[1:0];

  // Operation decode and alignment check.
  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    case (mem_op)
      OP_LB, OP_LBU:  is_load = 1'b1;
      OP_LH, OP_LHU: begin
        is_load    = 1'b1;
        misaligned = off[0];
      end
      OP_LW: begin
        is_load    = 1'b1;
        misaligned = (off != 2'b00);
      end
      OP_SB:          is_store = 1'b1;
      OP_SH: begin
        is_store   = 1'b1;
        misaligned = off[0];
      end
      OP_SW: begin
        is_store   = 1'b1;
        misaligned = (off != 2'b00);
      end
      default: ;
    endcase
  end

  // FSM state and load-data capture register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rdata_q <= 32'd0;
    end else begin
      state <= state_nxt;
      if (capture) rdata_q <= bus.dbus_rdata;
    end
  end

  // Next-state and request generation; ack only counts while a request is up.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if ((is_load || is_store) && !misaligned) begin
          req = 1'b1;
          if (bus.dbus_ack) begin
            capture   = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        req = 1'b1;
        if (bus.dbus_ack) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      // EX/MEM advances at the end of DONE, so the op is never reissued.
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Big-endian byte lanes and replicated store data.
  always_comb begin
    lane_sel  = 4'b0000;
    store_dat = 32'd0;
    case (mem_op)
      OP_LB, OP_LBU:  lane_sel = 4'b1000 >> off;
      OP_LH, OP_LHU:  lane_sel = off[1] ? 4'b0011 : 4'b1100;
      OP_LW:          lane_sel = 4'b1111;
      OP_SB: begin
        lane_sel  = 4'b1000 >> off;
        store_dat = {4{mem_sdata[7:0]}};
      end
      OP_SH: begin
        lane_sel  = off[1] ? 4'b0011 : 4'b1100;
        store_dat = {2{mem_sdata[15:0]}};
      end
      OP_SW: begin
        lane_sel  = 4'b1111;
        store_dat = mem_sdata;
      end
      default: ;
    endcase
  end

  assign bus.dbus_req   = req;
  assign bus.dbus_we    = req & is_store;
  assign bus.dbus_addr  = {mem_addr[31:2], 2'b00};
  assign bus.dbus_sel   = req ? lane_sel : 4'b0000;
  assign bus.dbus_wdata = (req && is_store) ? store_dat : 32'd0;

  // Lane extraction from the captured word; mem_addr is still valid because EX/MEM is held.
  always_comb begin
    case (off)
      2'd0:    load_byte = rdata_q[31:24];
      2'd1:    load_byte = rdata_q[23:16];
      2'd2:    load_byte = rdata_q[15:8];
      default: load_byte = rdata_q[7:0];
    endcase
    load_half = off[1] ? rdata_q[15:0] : rdata_q[31:16];
    case (mem_op)
      OP_LB:   load_ext = {{24{load_byte[7]}}, load_byte};
      OP_LBU:  load_ext = {24'd0, load_byte};
      OP_LH:   load_ext = {{16{load_half[15]}}, load_half};
      OP_LHU:  load_ext = {16'd0, load_half};
      default: load_ext = rdata_q;
    endcase
  end

  assign stallreq = req;
  assign exc_adel = (state == IDLE) & is_load & misaligned;
  assign exc_ades = (state == IDLE) & is_store & misaligned;

  assign wb_waddr = mem_waddr;
  assign wb_hi    = mem_hi;
  assign wb_lo    = mem_lo;
  assign wb_wreg  = mem_wreg & ~req & ~exc_adel & ~exc_ades;
  assign wb_whilo = mem_whilo & ~req;
  assign wb_wdata = (state == DONE && is_load) ? load_ext : mem_wdata;

endmodule

// File: tb/tb_mem_lsu.sv
// Purpose: randomized + directed bench for mem_lsu with a queue-based scoreboard.
// Latency: driver holds each op until stallreq is seen low; monitor retires it on that cycle.
// Backpressure: bus responder delays ack by a per-op number of wait cycles.
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_waddr;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic        mem_whilo;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr, mem_sdata;
  logic [4:0]  wb_waddr;
  logic        wb_wreg;
  logic [31:0] wb_wdata, wb_hi, wb_lo;
  logic        wb_whilo, stallreq, exc_adel, exc_ades;

  mem_lsu_if dbus_if ();

  mem_lsu dut (
    .clk(clk), .rst(rst),
    .mem_waddr(mem_waddr), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
    .bus(dbus_if),
    .wb_waddr(wb_waddr), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
    .stallreq(stallreq), .exc_adel(exc_adel), .exc_ades(exc_ades)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] wdata, hi, lo;
    logic        whilo, adel, ades;
    int          stalls;
    logic        we;
    logic [31:0] baddr, bwdata;
    logic [3:0]  sel;
  } exp_t;

  exp_t expq[$];
  exp_t me;
  bit   mon_en = 1'b0;
  int   stall_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Reference: bytes are numbered big-endian, byte 0 is bits [31:24].
  function automatic logic [31:0] model_load(input int width, input bit sgn,
                                              input logic [31:0] rd, input int off);
    logic [31:0] v;
    v = 32'd0;
    for (int k = 0; k < width; k++) v = (v << 8) | 32'(rd[8*(3-(off+k)) +: 8]);
    if (sgn && width < 4 && v[8*width-1]) v = v | ~((32'd1 << (8*width)) - 32'd1);
    return v;
  endfunction

  // Monitor / scoreboard: one retirement per non-stalled cycle.
  always @(negedge clk) begin
    if (mon_en && expq.size() > 0) begin
      me = expq[0];
      if (stallreq) begin
        stall_cnt++;
        chk1("stall_wb_wreg", wb_wreg, 1'b0);
        chk1("stall_wb_whilo", wb_whilo, 1'b0);
        chk1("stall_dbus_req", dbus_if.dbus_req, 1'b1);
        chk1("dbus_we", dbus_if.dbus_we, me.we);
        chk("dbus_addr", dbus_if.dbus_addr, me.baddr);
        chk("dbus_sel", 32'(dbus_if.dbus_sel), 32'(me.sel));
        if (me.we) chk("dbus_wdata", dbus_if.dbus_wdata, me.bwdata);
      end else begin
        chk("stall_cycles", 32'(stall_cnt), 32'(me.stalls));
        chk1("idle_dbus_req", dbus_if.dbus_req, 1'b0);
        chk1("wb_wreg", wb_wreg, me.wreg);
        chk("wb_waddr", 32'(wb_waddr), 32'(me.waddr));
        chk("wb_wdata", wb_wdata, me.wdata);
        chk("wb_hi", wb_hi, me.hi);
        chk("wb_lo", wb_lo, me.lo);
        chk1("wb_whilo", wb_whilo, me.whilo);
        chk1("exc_adel", exc_adel, me.adel);
        chk1("exc_ades", exc_ades, me.ades);
        void'(expq.pop_front());
        stall_cnt = 0;
      end
    end
  end

  // Present one op from EX/MEM and act as the memory until the stage lets it go.
  task automatic run_op(input int op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] waddr, input logic [31:0] wdata, input logic wreg,
                        input logic [31:0] rdata, input int waits, input bit stray);
    exp_t e;
    bit   is_ld, is_st, mis, on_bus, st, done;
    int   width, off, n;
    logic whilo;
    is_ld  = (op >= 1 && op <= 5);
    is_st  = (op >= 6 && op <= 8);
    width  = (op == 1 || op == 2 || op == 6) ? 1 : (op == 3 || op == 4 || op == 7) ? 2 : 4;
    off    = int'(addr % 4);
    mis    = (is_ld || is_st) && (off % width != 0);
    on_bus = (is_ld || is_st) && !mis;
    whilo  = (is_ld || is_st) ? 1'b0 : 1'($urandom);

    e.waddr  = waddr;
    e.hi     = $urandom;
    e.lo     = $urandom;
    e.whilo  = whilo;
    e.wreg   = mis ? 1'b0 : wreg;
    e.wdata  = (on_bus && is_ld) ? model_load(width, (op == 1 || op == 3), rdata, off) : wdata;
    e.adel   = mis && is_ld;
    e.ades   = mis && is_st;
    e.stalls = on_bus ? waits + 1 : 0;
    e.we     = is_st;
    e.baddr  = addr & ~32'd3;
    e.sel    = 4'b0000;
    for (int i = 0; i < 4; i++) e.sel[3-i] = (i >= off && i < off + width);
    e.bwdata = 32'd0;
    for (int i = 0; i < 4; i++) e.bwdata[8*i +: 8] = sdata[8*(i % width) +: 8];

    mem_op = 4'(op); mem_addr = addr; mem_sdata = sdata; mem_waddr = waddr;
    mem_wdata = wdata; mem_wreg = wreg; mem_hi = e.hi; mem_lo = e.lo; mem_whilo = whilo;
    expq.push_back(e);

    n = 0;
    done = 1'b0;
    while (!done) begin
      if (on_bus && n <= waits) dbus_if.dbus_ack = (n == waits);
      else dbus_if.dbus_ack = stray ? 1'($urandom) : 1'b0;
      dbus_if.dbus_rdata = (on_bus && n == waits) ? rdata : $urandom;
      @(negedge clk);
      st = stallreq;
      @(posedge clk);
      #1;
      dbus_if.dbus_ack = 1'b0;
      n++;
      if (!st) done = 1'b1;
      else if (n > 40) begin
        checks++;
        errors++;
        $display("FAIL op_timeout: op %0d still stalled after %0d cycles, required %0d", op, n, waits + 1);
        finish_sim();
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    mem_op = 4'd0; mem_addr = 32'd0; mem_sdata = 32'd0; mem_waddr = 5'd0;
    mem_wdata = 32'd0; mem_wreg = 1'b0; mem_hi = 32'd0; mem_lo = 32'd0; mem_whilo = 1'b0;
    dbus_if.dbus_ack = 1'b0;
    dbus_if.dbus_rdata = 32'd0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk1("rst_dbus_req", dbus_if.dbus_req, 1'b0);
    chk1("rst_dbus_we", dbus_if.dbus_we, 1'b0);
    chk("rst_dbus_sel", 32'(dbus_if.dbus_sel), 32'd0);
    chk("rst_dbus_wdata", dbus_if.dbus_wdata, 32'd0);
    chk("rst_dbus_addr", dbus_if.dbus_addr, 32'd0);
    chk1("rst_stallreq", stallreq, 1'b0);
    chk1("rst_exc_adel", exc_adel, 1'b0);
    chk1("rst_exc_ades", exc_ades, 1'b0);
    chk1("rst_wb_wreg", wb_wreg, 1'b0);
    chk("rst_wb_wdata", wb_wdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;

    // Directed cases.
    run_op(0, 32'h0000_0000, 32'd0, 5'd5, 32'h1234_5678, 1'b1, 32'd0, 0, 1'b1);    // ALU pass-through
    run_op(1, 32'h0000_0103, 32'd0, 5'd7, 32'h0000_0103, 1'b1, 32'h0000_0080, 2, 1'b0); // LB
    run_op(2, 32'h0000_0103, 32'd0, 5'd8, 32'h0000_0103, 1'b1, 32'h0000_0080, 2, 1'b0); // LBU
    run_op(7, 32'h0000_0202, 32'h0000_ABCD, 5'd0, 32'h0000_0202, 1'b0, 32'd0, 1, 1'b1); // SH
    run_op(5, 32'h0000_0301, 32'd0, 5'd9, 32'h0000_0301, 1'b1, 32'd0, 0, 1'b1);      // misaligned LW
    run_op(8, 32'h0000_0302, 32'h1111_2222, 5'd0, 32'h0000_0302, 1'b0, 32'd0, 0, 1'b1); // misaligned SW
    run_op(5, 32'h0000_0400, 32'd0, 5'd10, 32'h0000_0400, 1'b1, 32'hDEAD_BEEF, 0, 1'b0); // LW, same-cycle ack
    run_op(5, 32'h0000_0404, 32'd0, 5'd11, 32'h0000_0404, 1'b1, 32'hCAFE_F00D, 0, 1'b1); // back-to-back LW
    run_op(3, 32'h0000_0502, 32'd0, 5'd12, 32'h0000_0502, 1'b1, 32'h1234_8001, 1, 1'b0); // LH, low half
    run_op(4, 32'h0000_0500, 32'd0, 5'd13, 32'h0000_0500, 1'b1, 32'hF00F_1234, 0, 1'b0); // LHU, high half

    // Asynchronous reset while a LW waits for ack.
    mon_en = 1'b0;
    mem_op = 4'd5; mem_addr = 32'h0000_0600; mem_wreg = 1'b1; mem_waddr = 5'd3;
    dbus_if.dbus_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("wait_stallreq", stallreq, 1'b1);
    #2;
    rst = 1'b0;
    mem_op = 4'd0; mem_addr = 32'd0; mem_wreg = 1'b0; mem_waddr = 5'd0;
    #1;
    chk1("arst_dbus_req", dbus_if.dbus_req, 1'b0);
    chk1("arst_stallreq", stallreq, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    dbus_if.dbus_ack = 1'b1;
    dbus_if.dbus_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk1("stray_ack_stallreq", stallreq, 1'b0);
    chk1("stray_ack_dbus_req", dbus_if.dbus_req, 1'b0);
    @(posedge clk);
    #1;
    dbus_if.dbus_ack = 1'b0;
    @(posedge clk);
    #1;
    stall_cnt = 0;
    mon_en = 1'b1;
    run_op(5, 32'h0000_0700, 32'd0, 5'd4, 32'h0000_0700, 1'b1, 32'h0BAD_F00D, 1, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 250; t++) begin
      int   op;
      logic [31:0] a;
      op = int'($urandom_range(0, 15));
      a  = $urandom;
      run_op(op, a, $urandom, 5'($urandom), $urandom,
             (op >= 6 && op <= 8) ? 1'b0 : ((op >= 1 && op <= 5) ? 1'b1 : 1'($urandom)),
             $urandom, int'($urandom_range(0, 3)), 1'($urandom));
    end

    repeat (2) @(posedge clk);
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, required 0", expq.size());
    end
    finish_sim();
  end
endmodule
